// File: rtl/rv32i_pkg.sv
// Shared constants and the control bundle for the RV32I decode/execute slice.
package rv32i_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation {bit30, funct3}; 1001 is the pass-B slot
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_SRA    = 4'b1101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_PASS_B = 4'b1001;

    // Branch operation: none, unconditional, or conditional prefix + funct3
    localparam logic [4:0] BR_NONE     = 5'b00000;
    localparam logic [4:0] BR_UNCOND   = 5'b01000;
    localparam logic [1:0] BR_COND_PFX = 2'b10;

    // Conditional branch funct3 codes
    localparam logic [2:0] BF_EQ  = 3'b000;
    localparam logic [2:0] BF_NE  = 3'b001;
    localparam logic [2:0] BF_LT  = 3'b100;
    localparam logic [2:0] BF_GE  = 3'b101;
    localparam logic [2:0] BF_LTU = 3'b110;
    localparam logic [2:0] BF_GEU = 3'b111;

    // Immediate formats seen by the external immediate generator
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b101;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_J = 3'b110;

    // Register write-back source
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Decoded control for one instruction
    typedef struct packed {
        logic       a_pc;      // ALU A = pc instead of rs1_data
        logic       b_imm;     // ALU B = imm_ext instead of rs2_data
        logic [3:0] alu_op;
        logic [4:0] br_op;
        logic       ru_wr;
        logic       dm_wr;
        logic [1:0] wb_src;
        logic [2:0] dm_ctrl;
        logic [2:0] imm_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/rv32i_alu.sv
// 32-bit integer ALU; unassigned operation codes produce zero.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // Operation select; arithmetic wraps naturally at 32 bits.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_SLL:    y = a << shamt;
            ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:   y = {31'b0, a < b};
            ALU_XOR:    y = a ^ b;
            ALU_SRL:    y = a >> shamt;
            ALU_SRA:    y = $unsigned($signed(a) >>> shamt);
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_PASS_B: y = b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_branch_cmp.sv
// Branch resolution: compares rs1 against rs2 and decides whether to redirect.
module rv32i_branch_cmp
    import rv32i_pkg::*;
(
    input  logic [4:0]  br_op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        take
);

    logic eq, lt, ltu;
    assign eq  = (rs1 == rs2);
    assign lt  = ($signed(rs1) < $signed(rs2));
    assign ltu = (rs1 < rs2);

    // Taken decision; reserved conditional codes (010/011) never redirect.
    always_comb begin
        take = 1'b0;
        if (br_op == BR_UNCOND) begin
            take = 1'b1;
        end else if (br_op[4:3] == BR_COND_PFX) begin
            case (br_op[2:0])
                BF_EQ:   take = eq;
                BF_NE:   take = ~eq;
                BF_LT:   take = lt;
                BF_GE:   take = ~lt;
                BF_LTU:  take = ltu;
                BF_GEU:  take = ~ltu;
                default: take = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_decoder.sv
// Control decoder: maps the instruction word onto the ctrl_t bundle.
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign bit30  = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Defaults describe the illegal-opcode response; legal opcodes override.
    always_comb begin
        ctrl         = '0;
        ctrl.alu_op  = ALU_ADD;
        ctrl.br_op   = BR_NONE;
        ctrl.wb_src  = WB_ALU;
        ctrl.imm_src = IMM_I;
        ctrl.b_imm   = 1'b1;
        ctrl.illegal = 1'b1;
        unique case (opcode)
            OP_R: begin
                ctrl.illegal = 1'b0;
                ctrl.b_imm   = 1'b0;
                ctrl.alu_op  = {bit30, funct3};
                ctrl.ru_wr   = 1'b1;
            end
            OP_I_ALU: begin
                ctrl.illegal = 1'b0;
                // bit30 only distinguishes SRAI from SRLI; elsewhere it is immediate data
                ctrl.alu_op  = {(funct3 == 3'b101) ? bit30 : 1'b0, funct3};
                ctrl.ru_wr   = 1'b1;
            end
            OP_LOAD: begin
                ctrl.illegal = 1'b0;
                ctrl.ru_wr   = 1'b1;
                ctrl.wb_src  = WB_MEM;
                ctrl.dm_ctrl = funct3;
            end
            OP_STORE: begin
                ctrl.illegal = 1'b0;
                ctrl.dm_wr   = 1'b1;
                ctrl.dm_ctrl = funct3;
                ctrl.imm_src = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.illegal = 1'b0;
                ctrl.a_pc    = 1'b1;
                ctrl.br_op   = {BR_COND_PFX, funct3};
                ctrl.imm_src = IMM_B;
            end
            OP_JAL: begin
                ctrl.illegal = 1'b0;
                ctrl.a_pc    = 1'b1;
                ctrl.br_op   = BR_UNCOND;
                ctrl.ru_wr   = 1'b1;
                ctrl.wb_src  = WB_PC4;
                ctrl.imm_src = IMM_J;
            end
            OP_JALR: begin
                ctrl.illegal = 1'b0;
                ctrl.br_op   = BR_UNCOND;
                ctrl.ru_wr   = 1'b1;
                ctrl.wb_src  = WB_PC4;
            end
            OP_LUI: begin
                ctrl.illegal = 1'b0;
                ctrl.alu_op  = ALU_PASS_B;
                ctrl.ru_wr   = 1'b1;
                ctrl.imm_src = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.illegal = 1'b0;
                ctrl.a_pc    = 1'b1;
                ctrl.ru_wr   = 1'b1;
                ctrl.imm_src = IMM_U;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_execute.sv
// Single-cycle decode + execute: operand muxes around decoder, ALU and
// branch unit, plus a sticky illegal-opcode flag.
module rv32i_decode_execute
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm_ext,
    output logic [31:0] alu_res,
    output logic        next_pc_src,
    output logic        ru_wr,
    output logic        dm_wr,
    output logic [1:0]  ru_data_wr_src,
    output logic [2:0]  dm_ctrl,
    output logic [2:0]  imm_src,
    output logic        illegal_instr
);

    ctrl_t       ctrl;
    logic [31:0] alu_a, alu_b;

    rv32i_decoder u_dec (
        .instr (instr),
        .ctrl  (ctrl)
    );

    assign alu_a = ctrl.a_pc  ? pc      : rs1_data;
    assign alu_b = ctrl.b_imm ? imm_ext : rs2_data;

    rv32i_alu u_alu (
        .op (ctrl.alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_res)
    );

    rv32i_branch_cmp u_br (
        .br_op (ctrl.br_op),
        .rs1   (rs1_data),
        .rs2   (rs2_data),
        .take  (next_pc_src)
    );

    assign ru_wr          = ctrl.ru_wr;
    assign dm_wr          = ctrl.dm_wr;
    assign ru_data_wr_src = ctrl.wb_src;
    assign dm_ctrl        = ctrl.dm_ctrl;
    assign imm_src        = ctrl.imm_src;

    // Sticky illegal flag; reset takes priority over a coincident illegal opcode.
    always_ff @(posedge clk) begin
        if (rst)
            illegal_instr <= 1'b0;
        else if (ctrl.illegal)
            illegal_instr <= 1'b1;
    end

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Directed scoreboard bench for rv32i_decode_execute.
module tb_rv32i_decode_execute;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0000_0013;
    logic [31:0] pc = '0, rs1_data = '0, rs2_data = '0, imm_ext = '0;
    logic [31:0] alu_res;
    logic        next_pc_src, ru_wr, dm_wr, illegal_instr;
    logic [1:0]  ru_data_wr_src;
    logic [2:0]  dm_ctrl, imm_src;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] alu;
        logic        npc;
        logic        ru;
        logic        dm;
        logic [1:0]  wb;
        logic [2:0]  dmc;
        logic [2:0]  imm;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    rv32i_decode_execute dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .pc             (pc),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .imm_ext        (imm_ext),
        .alu_res        (alu_res),
        .next_pc_src    (next_pc_src),
        .ru_wr          (ru_wr),
        .dm_wr          (dm_wr),
        .ru_data_wr_src (ru_data_wr_src),
        .dm_ctrl        (dm_ctrl),
        .imm_src        (imm_src),
        .illegal_instr  (illegal_instr)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "alu_res",        alu_res,        e.alu);
            cmp(e.tag, "next_pc_src",    {31'b0, next_pc_src},    {31'b0, e.npc});
            cmp(e.tag, "ru_wr",          {31'b0, ru_wr},          {31'b0, e.ru});
            cmp(e.tag, "dm_wr",          {31'b0, dm_wr},          {31'b0, e.dm});
            cmp(e.tag, "ru_data_wr_src", {30'b0, ru_data_wr_src}, {30'b0, e.wb});
            cmp(e.tag, "dm_ctrl",        {29'b0, dm_ctrl},        {29'b0, e.dmc});
            cmp(e.tag, "imm_src",        {29'b0, imm_src},        {29'b0, e.imm});
            cmp(e.tag, "illegal_instr",  {31'b0, illegal_instr},  {31'b0, e.ill});
        end
    endtask

    // Drive one instruction just after a rising edge, queue its expectation,
    // and compare on the following falling edge.
    task automatic step(input string tag, input logic r, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] e_alu, input logic e_npc, input logic e_ru, input logic e_dm,
                        input logic [1:0] e_wb, input logic [2:0] e_dmc, input logic [2:0] e_imm,
                        input logic e_ill);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; instr = i; pc = p; rs1_data = a; rs2_data = b; imm_ext = im;
        e.tag = tag; e.alu = e_alu; e.npc = e_npc; e.ru = e_ru; e.dm = e_dm;
        e.wb = e_wb; e.dmc = e_dmc; e.imm = e_imm; e.ill = e_ill;
        sb.push_back(e);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        //    tag          rst instr         pc        rs1           rs2           imm           alu           npc ru dm wb     dmc     imm     ill
        step("reset",      1, 32'h00000013, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 0, 2'b00, 3'b000, 3'b000, 0);
        step("sub",        0, 32'h40208033, 32'h0,   32'd5,        32'd7,        32'h0,        32'hFFFFFFFE, 0, 1, 0, 2'b00, 3'b000, 3'b000, 0);
        step("srai",       0, 32'h4010D093, 32'h0,   32'h80000000, 32'h0,        32'h401,      32'hC0000000, 0, 1, 0, 2'b00, 3'b000, 3'b000, 0);
        step("addi_b30",   0, 32'h40000093, 32'h0,   32'd1,        32'h0,        32'h400,      32'h401,      0, 1, 0, 2'b00, 3'b000, 3'b000, 0);
        step("slt",        0, 32'h0020A033, 32'h0,   32'hFFFFFFFF, 32'd1,        32'h0,        32'h1,        0, 1, 0, 2'b00, 3'b000, 3'b000, 0);
        step("sltu",       0, 32'h0020B033, 32'h0,   32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        0, 1, 0, 2'b00, 3'b000, 3'b000, 0);
        step("undef_op",   0, 32'h4020A033, 32'h0,   32'd5,        32'd7,        32'h0,        32'h0,        0, 1, 0, 2'b00, 3'b000, 3'b000, 0);
        step("bltu",       0, 32'h0020E463, 32'h100, 32'd1,        32'hFFFFFFFF, 32'd8,        32'h108,      1, 0, 0, 2'b00, 3'b000, 3'b101, 0);
        step("blt",        0, 32'h0020C463, 32'h100, 32'd1,        32'hFFFFFFFF, 32'd8,        32'h108,      0, 0, 0, 2'b00, 3'b000, 3'b101, 0);
        step("beq",        0, 32'h00208463, 32'h0,   32'd9,        32'd9,        32'd8,        32'h8,        1, 0, 0, 2'b00, 3'b000, 3'b101, 0);
        step("br_f3_010",  0, 32'h0020A463, 32'h0,   32'd9,        32'd9,        32'd8,        32'h8,        0, 0, 0, 2'b00, 3'b000, 3'b101, 0);
        step("jal",        0, 32'h008000EF, 32'h20,  32'h0,        32'h0,        32'd8,        32'h28,       1, 1, 0, 2'b10, 3'b000, 3'b110, 0);
        step("jalr",       0, 32'h000080E7, 32'h0,   32'h301,      32'h0,        32'h10,       32'h311,      1, 1, 0, 2'b10, 3'b000, 3'b000, 0);
        step("lbu",        0, 32'h0040C103, 32'h0,   32'h200,      32'h0,        32'd4,        32'h204,      0, 1, 0, 2'b01, 3'b100, 3'b000, 0);
        step("sw",         0, 32'h0020A223, 32'h0,   32'h1000,     32'h55,       32'd4,        32'h1004,     0, 0, 1, 2'b00, 3'b010, 3'b001, 0);
        step("lui",        0, 32'h123450B7, 32'h0,   32'hDEADBEEF, 32'h0,        32'h12345000, 32'h12345000, 0, 1, 0, 2'b00, 3'b000, 3'b010, 0);
        step("auipc",      0, 32'h00001097, 32'h40,  32'hDEADBEEF, 32'h0,        32'h1000,     32'h1040,     0, 1, 0, 2'b00, 3'b000, 3'b010, 0);
        step("illegal",    0, 32'h0000007F, 32'h0,   32'd3,        32'd9,        32'd4,        32'h7,        0, 0, 0, 2'b00, 3'b000, 3'b000, 0);
        step("ill_set",    0, 32'h00000013, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 0, 2'b00, 3'b000, 3'b000, 1);
        step("ill_hold",   0, 32'h00000013, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 0, 2'b00, 3'b000, 3'b000, 1);
        step("rst_vs_ill", 1, 32'h0000007F, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 2'b00, 3'b000, 3'b000, 1);
        step("ill_clear",  0, 32'h00000013, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 0, 2'b00, 3'b000, 3'b000, 0);
        step("ill_stay0",  0, 32'h00000013, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 0, 2'b00, 3'b000, 3'b000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_decode_execute.md
RV32I_DECODE_EXECUTE -- requirements
Module: rv32i_decode_execute

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have these inputs: instr  in  32  current instruction; pc  in  32  current PC; rs1_data  in  32  register rs1 value; rs2_data  in  32  register rs2 value; imm_ext  in  32  sign-extended immediate from the external immediate generator.
REQ-003 SHALL have these outputs: alu_res  out  32  ALU result; next_pc_src  out  1  1 = take alu_res as next PC; ru_wr  out  1  register write enable; dm_wr  out  1  data-memory write enable; ru_data_wr_src  out  2  00 ALU, 01 memory, 10 PC+4; dm_ctrl  out  3  memory size/sign (= funct3); imm_src  out  3  immediate format; illegal_instr  out  1  sticky illegal-opcode flag.

Function
REQ-004 SHALL make every output except illegal_instr purely combinational from instr, pc, rs1_data, rs2_data and imm_ext, with zero-cycle latency.
REQ-005 SHALL decode opcode instr[6:0] as follows: 0110011 R; 0010011 I-ALU; 0000011 load; 0100011 store; 1100011 branch; 1101111 JAL; 1100111 JALR; 0110111 LUI; 0010111 AUIPC.
REQ-006 SHALL set imm_src by format: I/load/JALR 000; S 001; B 101; U 010; J 110; R 000.
REQ-007 SHALL select ALU A = pc for branch, JAL and AUIPC, and rs1_data for all other instructions; ALU B = rs2_data for R-type, and imm_ext for all other instructions.
REQ-008 SHALL encode the 4-bit ALU operation as {bit30, funct3}: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, and SHALL use 1001 for pass-B.
REQ-009 SHALL drive bit30 of the ALU operation from the instruction only for R-type and for I-ALU with funct3=101; for all other instructions it SHALL be 0, except LUI, which SHALL use pass-B.
REQ-010 SHALL use ADD for the load, store, branch, JAL, JALR and AUIPC ALU operation.
REQ-011 SHALL use only B[4:0] as the shift amount; SLT SHALL compare signed, SLTU unsigned; SRA SHALL be arithmetic; arithmetic SHALL wrap modulo 2^32.
REQ-012 SHALL make any undefined ALU operation encoding produce alu_res = 0.
REQ-013 SHALL compute the 5-bit branch operation as: 00000 none; 01000 unconditional (JAL, JALR); {2'b10, funct3} for branches.
REQ-014 SHALL make the branch unit compare rs1_data against rs2_data and set next_pc_src = 1 for: none → never; unconditional → always; 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge. Branch funct3 010/011 → 0.
REQ-015 SHALL set ru_wr = 1 for R, I-ALU, load, JAL, JALR, LUI and AUIPC, and 0 otherwise.
REQ-016 SHALL set dm_wr = 1 only for store.
REQ-017 SHALL set ru_data_wr_src to 01 for load, 10 for JAL/JALR, and 00 otherwise.
REQ-018 SHALL set dm_ctrl = funct3 for load/store, and 000 otherwise.
REQ-019 SHALL leave the JALR target unmodified (bit 0 not cleared); alu_res = rs1_data + imm_ext.
REQ-020 SHALL treat any unlisted opcode as illegal: ru_wr=0, dm_wr=0, next_pc_src=0, ALU operation ADD, imm_src 000, ru_data_wr_src 00.
REQ-021 SHALL set illegal_instr to 1 on the clock edge after an illegal opcode is presented, and hold it at 1 until reset.

Reset
REQ-022 SHALL clear illegal_instr to 0 on a rising clk edge with rst=1; if rst and an illegal opcode occur together, rst SHALL win.
REQ-023 SHALL leave the combinational outputs unaffected by rst.

Structure
REQ-024 SHALL define the opcode, ALU operation, branch operation, imm_src and ru_data_wr_src constants in a shared package, rv32i_pkg.
REQ-025 SHALL be built from three sub-modules: decoder (control), rv32i_alu and rv32i_branch_cmp; the top SHALL hold only the operand muxes and the illegal_instr flag.

Verification
REQ-026 SHALL cover SUB: instr 0x40208033 (sub x0,x1,x2), rs1=5, rs2=7 → alu_res 0xFFFFFFFE, ru_wr=1, ru_data_wr_src 00, next_pc_src 0.
REQ-027 SHALL cover SRAI: instr 0x4010D093 (srai x1,x1,1), rs1=0x80000000, imm_ext=0x401 → alu_res 0xC0000000.
REQ-028 SHALL cover BLTU: instr 0x0020E463 (bltu x1,x2,8), rs1=1, rs2=0xFFFFFFFF, pc=0x100, imm_ext=8 → next_pc_src 1, alu_res 0x108. With BLT (funct3 100) on the same operands → next_pc_src 0.
REQ-029 SHALL cover JAL: instr 0x008000EF, pc=0x20, imm_ext=8 → alu_res 0x28, next_pc_src 1, ru_wr 1, ru_data_wr_src 10.
REQ-030 SHALL cover store and LUI: sw (opcode 0100011, funct3 010) → dm_wr 1, ru_wr 0, dm_ctrl 010, imm_src 001. LUI with imm_ext=0x12345000 → alu_res 0x12345000.
REQ-031 SHALL cover the illegal opcode: opcode 1111111 → write enables 0, illegal_instr 1 on the next edge and held; rst=1 on an edge → 0.
